lz77_huffman_decoder: RTL and testbench



---
 rtl/lz77_huffman_decoder.sv | 130 +++++++++++++
 tb/tb_lz77_huffman_decoder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_huffman_decoder.sv
// lz77_huffman_decoder: expands {offset, length, code} tokens into a byte stream.
// Ports: clk/reset (async, active-high); tok_valid/tok_ready/tok_data token input;
// out_valid/out_ready/out_data byte output; eos end-of-stream pulse; err sticky error.
module lz77_huffman_decoder #(
  parameter int         OFF_W      = 3,
  parameter int         LEN_W      = 3,
  parameter int         HIST_DEPTH = 8,
  parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tok_valid,
  output logic                   tok_ready,
  input  logic [OFF_W+LEN_W+4:0] tok_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   eos,
  output logic                   err
);
  localparam int FW = $clog2(HIST_DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(HIST_DEPTH);
  localparam logic [4:0] END_CODE = 5'h1F;
  localparam logic [7:0] LUT [32] = '{BAD_CHAR,
    "e", "s", "i", "a", "r", "n", "t", "o", "l", "c", "d", "u", "g",
    "p", "m", "h", "b", "y", "f", "v", "k", "w", "z", "x", "j", "q",
    BAD_CHAR, BAD_CHAR, BAD_CHAR, BAD_CHAR, BAD_CHAR};
  typedef enum logic [1:0] {IDLE, COPY, LIT, END} state_t;
  state_t           state_q, state_d;
  logic [7:0]       hist_q [HIST_DEPTH];
  logic [7:0]       hist_d [HIST_DEPTH];
  logic [FW-1:0]    fill_q, fill_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [4:0]       code_q, code_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             eos_q, eos_d;
  logic             err_q, err_d;
  logic [OFF_W-1:0] tok_off;
  logic [LEN_W-1:0] tok_len;
  logic [4:0]       tok_code;
  logic             take;
  function automatic logic bad_code(input logic [4:0] c);
    return c == 5'd0 || (c >= 5'd27 && c <= 5'd30);
  endfunction
  assign tok_off   = tok_data[OFF_W+LEN_W+4 -: OFF_W];
  assign tok_len   = tok_data[LEN_W+4 -: LEN_W];
  assign tok_code  = tok_data[4:0];
  assign take      = out_valid_q && out_ready;
  assign tok_ready = state_q == IDLE && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign eos       = eos_q;
  assign err       = err_q;
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    off_d       = off_q;
    rem_d       = rem_q;
    code_d      = code_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    eos_d       = 1'b0;
    err_d       = err_q;
    // every accepted byte enters history; hist[0] is the most recent
    if (take) begin
      hist_d[0] = out_data_q;
      for (int i = 1; i < HIST_DEPTH; i++) hist_d[i] = hist_q[i-1];
      fill_d = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    end
    case (state_q)
      IDLE: if (tok_valid) begin
        off_d       = tok_off;
        code_d      = tok_code;
        rem_d       = (tok_off == '0) ? '0 : tok_len;
        err_d       = err_q || (tok_off == '0 && tok_len != '0) || FW'(tok_off) > fill_q || bad_code(tok_code);
        state_d     = (rem_d != '0) ? COPY : LIT;
        out_valid_d = (rem_d != '0) || tok_code != END_CODE;
        out_data_d  = (rem_d != '0) ? hist_q[tok_off - 1'b1] : LUT[tok_code];
      end
      COPY: if (take) begin
        // next copy byte reads the already-shifted history so overlaps replicate
        rem_d       = rem_q - 1'b1;
        state_d     = (rem_q == LEN_W'(1)) ? LIT : COPY;
        out_valid_d = (rem_q != LEN_W'(1)) || code_q != END_CODE;
        out_data_d  = (rem_q == LEN_W'(1)) ? LUT[code_q] : hist_d[off_q - 1'b1];
      end
      LIT: begin
        if (code_q == END_CODE) begin
          state_d = END;
          eos_d   = 1'b1;
        end else if (take) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        fill_d  = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hist_q      <= '{default: '0};
      fill_q      <= '0;
      off_q       <= '0;
      rem_q       <= '0;
      code_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      eos_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      off_q       <= off_d;
      rem_q       <= rem_d;
      code_q      <= code_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      eos_q       <= eos_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_lz77_huffman_decoder.sv
// tb_lz77_huffman_decoder: randomized and directed checks against a queue-based reference model.
module tb_lz77_huffman_decoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic [10:0] tok_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        eos;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  got[$];
  int          eos_cnt = 0;
  bit          bp_en = 1'b0;

  logic [7:0]  m_hist[$];
  int          m_fill;
  bit          m_err;
  logic [7:0]  exp_q[$];
  int          exp_eos = 0;

  lz77_huffman_decoder dut (
    .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_data(tok_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .eos(eos), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_hist = {};
    repeat (8) m_hist.push_back(8'h00);
    m_fill = 0;
    m_err = 1'b0;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    exp_q.push_back(b);
    m_hist.push_front(b);
    void'(m_hist.pop_back());
    if (m_fill < 8) m_fill++;
  endfunction

  function automatic void model_tok(input logic [10:0] t);
    int off = int'(t[10:8]);
    int len = int'(t[7:5]);
    int code = int'(t[4:0]);
    string chars = "esiarntolcdugpmhbyfvkwzxjq";
    if (off == 0) begin
      if (len != 0) m_err = 1'b1;
      len = 0;
    end
    if (off > m_fill) m_err = 1'b1;
    for (int i = 0; i < len; i++) m_push(m_hist[off-1]);
    if (code == 31) begin
      exp_eos++;
      m_fill = 0;
    end else if (code >= 1 && code <= 26) m_push(chars[code-1]);
    else begin
      m_err = 1'b1;
      m_push(8'h3F);
    end
  endfunction

  task automatic monitor();
    bit stall = 1'b0;
    logic [7:0] stall_data = '0;
    forever begin
      @(negedge clk);
      if (reset) stall = 1'b0;
      else begin
        if (stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== stall_data) begin
            errors++;
            $display("FAIL hold out_valid=%0b out_data=%h required 1/%h", out_valid, out_data, stall_data);
          end
        end
        checks++;
        if (tok_ready && out_valid) begin
          errors++;
          $display("FAIL ready_excl tok_ready=1 with out_valid=1 required tok_ready=0");
        end
        if (out_valid && out_ready) got.push_back(out_data);
        if (eos) eos_cnt++;
        stall = out_valid && !out_ready;
        stall_data = out_data;
      end
    end
  endtask

  task automatic bp_drive();
    forever begin
      @(posedge clk);
      #2;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tok_valid = 1'b0;
    out_ready = 1'b1;
    bp_en = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    got = {};
    exp_q = {};
    eos_cnt = 0;
    exp_eos = 0;
  endtask

  task automatic run_tok(input logic [10:0] t, output int cyc);
    int n = 0;
    model_tok(t);
    tok_data = t;
    tok_valid = 1'b1;
    while (!tok_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 tok_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!tok_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    cyc = n;
    checks++;
    if (!tok_ready) begin
      errors++;
      $display("FAIL tok_timeout tok_ready=%0b required 1 within 300 cycles", tok_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (tok_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || eos !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals rdy=%0b vld=%0b data=%h eos=%0b err=%0b required 0/0/00/0/0", tok_ready, out_valid, out_data, eos, err);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (tok_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready tok_ready=%0b required 1", tok_ready);
    end
    model_reset();
  endtask

  task automatic test_literals();
    int c;
    apply_reset();
    run_tok(11'h004, c);
    run_tok(11'h007, c);
    run_tok(11'h01F, c);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL lit_count got %0d required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL lit_byte[%0d] got %h required %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (eos_cnt != exp_eos || err !== m_err) begin
      errors++;
      $display("FAIL lit_eos_err eos_cycles=%0d err=%0b required %0d/%0b", eos_cnt, err, exp_eos, m_err);
    end
  endtask

  task automatic test_overlap();
    int c;
    apply_reset();
    run_tok(11'h004, c);
    run_tok(11'h162, c);
    checks++;
    if (c != 4) begin
      errors++;
      $display("FAIL overlap_cycles busy=%0d required 4 (3 copy + 1 literal)", c);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL overlap_count got %0d required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL overlap_byte[%0d] got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int c;
    apply_reset();
    run_tok(11'h004, c);
    fork
      run_tok(11'h162, c);
      begin
        int n = 0;
        while (got.size() < 2 && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        checks++;
        if (got.size() < 2) begin
          errors++;
          $display("FAIL bp_start bytes=%0d required 2", got.size());
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_data !== 8'h61 || tok_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold vld=%0b data=%h rdy=%0b required 1/61/0", out_valid, out_data, tok_ready);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_byte[%0d] got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_offset_beyond_fill();
    int c;
    apply_reset();
    run_tok(11'h221, c);
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL ofs_err err=%0b required %0b", err, m_err);
    end
    run_tok(11'h004, c);
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL ofs_sticky err=%0b required %0b", err, m_err);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ofs_count got %0d required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ofs_byte[%0d] got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_code();
    int c;
    logic [10:0] toks [2] = '{11'h000, 11'h041};
    foreach (toks[k]) begin
      apply_reset();
      run_tok(toks[k], c);
      checks++;
      if (err !== m_err || got.size() != exp_q.size()) begin
        errors++;
        $display("FAIL bad_err tok=%h err=%0b bytes=%0d required %0b/%0d", toks[k], err, got.size(), m_err, exp_q.size());
      end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bad_byte tok=%h got %h required %h", toks[k], got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    int c;
    int n = 0;
    apply_reset();
    run_tok(11'h004, c);
    run_tok(11'h0E4, c);
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL mid_err_pre err=%0b required %0b", err, m_err);
    end
    model_tok(11'h1E4);
    tok_data = 11'h1E4;
    tok_valid = 1'b1;
    @(posedge clk);
    #1 tok_valid = 1'b0;
    while (got.size() < 4 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || tok_ready !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_abort vld=%0b err=%0b rdy=%0b data=%h required 0/0/0/00", out_valid, err, tok_ready, out_data);
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL mid_partial bytes=%0d required 4", got.size());
    end
    foreach (got[i]) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_byte[%0d] got %h required %h", i, got[i], exp_q[i]);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    got = {};
    exp_q = {};
    run_tok(11'h004, c);
    run_tok(11'h121, c);
    checks++;
    if (err !== m_err || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_post err=%0b bytes=%0d required %0b/%0d", err, got.size(), m_err, exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_post_byte[%0d] got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int c;
    apply_reset();
    bp_en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [10:0] t;
      if (k < 40) begin
        int off, len, code;
        off = (m_fill == 0) ? 0 : $urandom_range(1, (m_fill < 7) ? m_fill : 7);
        len = (off == 0) ? 0 : $urandom_range(0, 7);
        code = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(1, 26);
        t = {off[2:0], len[2:0], code[4:0]};
      end else t = 11'($urandom_range(0, 2047));
      run_tok(t, c);
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL rand_err tok#%0d=%h err=%0b required %0b", k, t, err, m_err);
      end
    end
    bp_en = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got.size() != exp_q.size() || eos_cnt != exp_eos) begin
      errors++;
      $display("FAIL rand_count bytes=%0d eos=%0d required %0d/%0d", got.size(), eos_cnt, exp_q.size(), exp_eos);
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_byte[%0d] got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    fork
      monitor();
      bp_drive();
    join_none
    test_reset();
    test_literals();
    test_overlap();
    test_backpressure();
    test_offset_beyond_fill();
    test_bad_code();
    test_reset_mid_copy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
